// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcodes and the arbiter state encoding.
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int NUM_REQ = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  // A lone requester always wins; on contention the priority pointer decides.
  function automatic logic pick_owner(input logic [NUM_REQ-1:0] r, input logic prio);
    case (r)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return prio;
    endcase
  endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the shared ALU and its controller.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t aluop;
  word_t  port_a;
  word_t  port_b;
  word_t  output_port;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu (
    input  aluop, port_a, port_b,
    output output_port, negative, overflow, zero
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU; overflow is meaningful only for ADD and SUB.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aluif
);

  word_t res;
  logic  ovf;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aluif.aluop)
      ALU_SLL:  res = aluif.port_a << aluif.port_b[4:0];
      ALU_SRL:  res = aluif.port_a >> aluif.port_b[4:0];
      ALU_ADD: begin
        res = aluif.port_a + aluif.port_b;
        ovf = (aluif.port_a[31] == aluif.port_b[31]) && (res[31] != aluif.port_a[31]);
      end
      ALU_SUB: begin
        res = aluif.port_a - aluif.port_b;
        ovf = (aluif.port_a[31] != aluif.port_b[31]) && (res[31] != aluif.port_a[31]);
      end
      ALU_AND:  res = aluif.port_a & aluif.port_b;
      ALU_OR:   res = aluif.port_a | aluif.port_b;
      ALU_XOR:  res = aluif.port_a ^ aluif.port_b;
      ALU_NOR:  res = ~(aluif.port_a | aluif.port_b);
      ALU_SLT:  res = {31'b0, $signed(aluif.port_a) < $signed(aluif.port_b)};
      ALU_SLTU: res = {31'b0, aluif.port_a < aluif.port_b};
      default:  res = '0;
    endcase
  end

  assign aluif.output_port = res;
  assign aluif.negative    = res[31];
  assign aluif.overflow    = ovf;
  assign aluif.zero        = (res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to one shared ALU: IDLE -> EXEC -> RESP.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  req,
  input  logic [3:0]  ALUOP0,
  input  logic [3:0]  ALUOP1,
  input  logic [31:0] port_A0,
  input  logic [31:0] port_B0,
  input  logic [31:0] port_A1,
  input  logic [31:0] port_B1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [31:0] result,
  output logic        negative,
  output logic        overflow,
  output logic        zero,
  output logic        busy
);

  arb_state_t state_reg, state_next;
  logic       owner_reg;
  logic       prio_reg;
  logic       sel_owner;
  aluop_t     op_reg;
  word_t      a_reg, b_reg;
  word_t      result_reg;
  logic       neg_reg, ovf_reg, zero_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic [NUM_REQ-1:0] owner_onehot;

  aluop_t op_in [NUM_REQ];
  word_t  a_in  [NUM_REQ];
  word_t  b_in  [NUM_REQ];

  assign op_in[0] = aluop_t'(ALUOP0);
  assign op_in[1] = aluop_t'(ALUOP1);
  assign a_in[0]  = port_A0;
  assign a_in[1]  = port_A1;
  assign b_in[0]  = port_B0;
  assign b_in[1]  = port_B1;

  assign sel_owner = pick_owner(req, prio_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign owner_onehot[gi] = (owner_reg == 1'(gi));
    end
  endgenerate

  alu_if aluif ();

  // The ALU only ever sees the latched operands, so input changes mid-op are harmless.
  assign aluif.aluop  = op_reg;
  assign aluif.port_a = a_reg;
  assign aluif.port_b = b_reg;

  alu u_alu (.aluif(aluif));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    gnt  = busy ? owner_onehot : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_reg  <= 1'b0;
      prio_reg   <= RR_INIT;
      op_reg     <= ALU_SLL;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      neg_reg    <= 1'b0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
      done_reg   <= '0;
    end else begin
      if (state_reg == IDLE && (|req)) begin
        owner_reg <= sel_owner;
        op_reg    <= op_in[sel_owner];
        a_reg     <= a_in[sel_owner];
        b_reg     <= b_in[sel_owner];
      end
      if (state_reg == EXEC) begin
        result_reg <= aluif.output_port;
        neg_reg    <= aluif.negative;
        ovf_reg    <= aluif.overflow;
        zero_reg   <= aluif.zero;
      end
      // Completion is the only event that moves the priority pointer.
      if (state_reg == RESP) begin
        prio_reg <= ~owner_reg;
      end
      done_reg <= (state_reg == RESP) ? owner_onehot : '0;
    end
  end

  assign done     = done_reg;
  assign result   = result_reg;
  assign negative = neg_reg;
  assign overflow = ovf_reg;
  assign zero     = zero_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, selects the requester that holds priority after reset (0 or 1).
REQ-002 Port CLK, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 Port nRST, input, 1, asynchronous active-low reset.
REQ-004 Port req, input, 2, per-requester level request; bit i belongs to requester i.
REQ-005 Port ALUOP0 / ALUOP1, input, 4 each, operation code (aluop encoding from cpu_types_pkg) for requester 0 / 1.
REQ-006 Port port_A0, port_B0, port_A1, port_B1, input, word_t (32) each, operands per requester.
REQ-007 Port gnt, output, 2, one-hot current owner; all-zero when idle.
REQ-008 Port done, output, 2, one-cycle completion pulse to the owner.
REQ-009 Port result, output, word_t, registered ALU result; valid while done is high, held until the next capture.
REQ-010 Port negative, overflow, zero, output, 1 each, registered ALU flags, captured with result.
REQ-011 Port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-013 IDLE: if req is nonzero, select an owner, latch its ALUOP/A/B into operand registers, set gnt, and go to EXEC; otherwise remain in IDLE.
REQ-014 Owner selection: single requester -> that requester; both requesting -> the requester named by the priority pointer.
REQ-015 EXEC: drive the shared ALU from the latched operands only, capture output_port and flags into the result registers, and go to RESP.
REQ-016 RESP: done[owner]=1 for this cycle only, gnt unchanged, priority pointer <= the non-owner, next state IDLE.
REQ-017 Latency: request sampled at edge k, done high in the cycle after edge k+2; result valid in that same cycle.
REQ-018 Throughput: at most one operation per 3 cycles; back-to-back requests alternate owners when both are held.
REQ-019 req is sampled only in IDLE; req/operand changes in EXEC or RESP are ignored.
REQ-020 A req still high in the IDLE cycle after done counts as a new request.
REQ-021 Priority SHALL update only on completion, never on a request with no competitor.
REQ-022 done and gnt SHALL never have more than one bit set.
REQ-023 result and the flags are driven by the registers only, never combinationally by the ALU.

Reset
REQ-024 nRST low SHALL force: state=IDLE, gnt=0, done=0, busy=0, result=0, negative=0, overflow=0, zero=0, operand registers=0, priority pointer=RR_INIT.
REQ-025 Reset asserted during EXEC or RESP SHALL abort the operation with no done pulse; the first request after release is arbitrated fresh.

Structure
REQ-026 The state enum arb_state_t (IDLE, EXEC, RESP) SHALL live in cpu_types_pkg alongside word_t and the aluop encodings.
REQ-027 The block SHALL instantiate the existing alu as its sole sub-module, connected through one alu_if instance (alu modport).

Verification
REQ-028 Single add: req=01, ALU_ADD, A0=5, B0=7 -> gnt=01 for 2 cycles, done=01 on the third cycle, result=12, zero=0.
REQ-029 Contention: req=11 from reset with RR_INIT=0, held -> owner 0 first, then owner 1, then owner 0; done alternates 01,10,01 at 3-cycle spacing.
REQ-030 Flags: ALU_SUB A1=3, B1=3 -> result=0, zero=1; ALU_ADD 0x7FFFFFFF+1 -> result=0x80000000, overflow=1, negative=1.
REQ-031 Operand hold: change port_A0 from 5 to 99 during EXEC -> result still reflects 5.
REQ-032 Mid-op reset: pulse nRST low during EXEC -> no done pulse, all outputs 0, next request is served by the RR_INIT requester when both request.
REQ-033 Idle: req=00 for 10 cycles -> busy=0, gnt=00, done=00, result unchanged.
